life_grid_core: RTL and testbench

Parametrised Conway Life engine holding a WIDTH×HEIGHT cell array in flops. It computes one generation row-serially, one row per clock, under B3/S23 rules. Borders are selectable per generation: toroidal wrap or dead (zero) border. It sits between the input/command logic (row loads, step/run, clear) and the terminal/VGA renderer, which reads rows through a registered read port.

---
 rtl/life_grid_core.sv | 163 ++++++++++++++++
 tb/tb_life_grid_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_grid_core.sv
// Conway Life engine (B3/S23): WIDTH x HEIGHT grid held in flops, one row updated per clock.
// Selectable toroidal or dead border, with a registered row read port for the renderer.
module life_grid_core #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned ROW_W  = $clog2(HEIGHT),
    parameter int unsigned GEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             run,
    input  logic             wrap_en,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [ROW_W-1:0] rd_row,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen_count,
    output logic             extinct
);

    localparam int unsigned LAST = HEIGHT - 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] grid_q [HEIGHT];
    logic [WIDTH-1:0] grid_d [HEIGHT];
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] first_q, first_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             extinct_q, extinct_d;
    logic             wrap_q, wrap_d;
    logic             any_q, any_d;

    logic [WIDTH-1:0] cur_row, below_row, new_row;
    logic [WIDTH+1:0] ext_above, ext_cur, ext_below;
    logic [3:0]       nbr_cnt;

    // Pads a row with its wrapped edge columns (or zeros for a dead border).
    function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] row, input logic wrap);
        return {wrap & row[0], row, wrap & row[WIDTH-1]};
    endfunction

    // Next-generation value for the row currently being processed.
    always_comb begin
        cur_row   = grid_q[r_q];
        below_row = '0;
        if (32'(r_q) < LAST) begin
            below_row = grid_q[ROW_W'(r_q + 1'b1)];
        end else if (wrap_q) begin
            below_row = first_q;
        end
        ext_above = extend(prev_q, wrap_q);
        ext_cur   = extend(cur_row, wrap_q);
        ext_below = extend(below_row, wrap_q);
        new_row   = '0;
        nbr_cnt   = '0;
        for (int c = 0; c < int'(WIDTH); c++) begin
            nbr_cnt = 4'(ext_above[c]) + 4'(ext_above[c+1]) + 4'(ext_above[c+2])
                    + 4'(ext_cur[c])                         + 4'(ext_cur[c+2])
                    + 4'(ext_below[c]) + 4'(ext_below[c+1]) + 4'(ext_below[c+2]);
            new_row[c] = (nbr_cnt == 4'd3) || (cur_row[c] && (nbr_cnt == 4'd2));
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        first_d   = first_q;
        prev_d    = prev_q;
        r_d       = r_q;
        gen_d     = gen_q;
        extinct_d = extinct_q;
        wrap_d    = wrap_q;
        any_d     = any_q;
        done_d    = 1'b0;
        rd_data_d = '0;
        if (32'(rd_row) < HEIGHT) begin
            rd_data_d = grid_q[rd_row];
        end

        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    for (int i = 0; i < int'(HEIGHT); i++) grid_d[i] = '0;
                    gen_d     = '0;
                    extinct_d = 1'b0;
                end else if (wr_en) begin
                    if (32'(wr_row) < HEIGHT) grid_d[wr_row] = wr_data;
                end else if (step || run) begin
                    wrap_d  = wrap_en;
                    first_d = grid_q[0];
                    prev_d  = wrap_en ? grid_q[LAST] : '0;
                    r_d     = '0;
                    any_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                grid_d[r_q] = new_row;
                prev_d      = cur_row;
                any_d       = any_q | (|new_row);
                r_d         = ROW_W'(r_q + 1'b1);
                if (32'(r_q) == LAST) begin
                    state_d   = IDLE;
                    gen_d     = gen_q + GEN_W'(1);
                    extinct_d = ~(any_q | (|new_row));
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            for (int i = 0; i < int'(HEIGHT); i++) grid_q[i] <= '0;
            rd_data_q <= '0;
            first_q   <= '0;
            prev_q    <= '0;
            r_q       <= '0;
            gen_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            extinct_q <= 1'b0;
            wrap_q    <= 1'b0;
            any_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            rd_data_q <= rd_data_d;
            first_q   <= first_d;
            prev_q    <= prev_d;
            r_q       <= r_d;
            gen_q     <= gen_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            extinct_q <= extinct_d;
            wrap_q    <= wrap_d;
            any_q     <= any_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;
    assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_grid_core.sv
// Directed + randomized bench for life_grid_core against a plain-arithmetic Life model.
module tb_life_grid_core;
    localparam int W = 32;
    localparam int H = 16;
    localparam int RW = 4;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          step = 1'b0, run = 1'b0, wrap_en = 1'b0, clear = 1'b0, wr_en = 1'b0;
    logic [RW-1:0] wr_row = '0, rd_row = '0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  rd_data;
    logic          busy, done, extinct;
    logic [GW-1:0] gen_count;

    life_grid_core #(.WIDTH(W), .HEIGHT(H), .ROW_W(RW), .GEN_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .run(run), .wrap_en(wrap_en),
        .clear(clear), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .done(done),
        .gen_count(gen_count), .extinct(extinct)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            passed = 0;
    logic [W-1:0]  m [H];
    logic [W-1:0]  saved [H];
    logic [GW-1:0] exp_gen = '0;
    logic          exp_ext = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: count the eight neighbours of every cell directly on the 2-D array.
    task automatic model_step(input bit wr);
        logic [W-1:0] nx [H];
        int cnt, rr, cc;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wr) begin
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            cnt += int'(m[rr][cc]);
                        end else if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                            cnt += int'(m[rr][cc]);
                        end
                    end
                end
                nx[r][c] = (cnt == 3) || (m[r][c] && cnt == 2);
            end
        end
        m = nx;
        exp_ext = 1'b1;
        for (int r = 0; r < H; r++) if (m[r] != '0) exp_ext = 1'b0;
        exp_gen = exp_gen + 16'd1;
    endtask

    task automatic write_row(input int r, input logic [W-1:0] d);
        wr_en = 1'b1; wr_row = RW'(r); wr_data = d;
        tick();
        wr_en = 1'b0;
        m[r] = d;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int r = 0; r < H; r++) m[r] = '0;
        exp_gen = '0;
        exp_ext = 1'b0;
    endtask

    task automatic check_grid(input string tag);
        for (int r = 0; r < H; r++) begin
            rd_row = RW'(r);
            tick();
            chk($sformatf("%s_row%0d", tag, r), 64'(rd_data), 64'(m[r]));
        end
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_gen"}, 64'(gen_count), 64'(exp_gen));
        chk({tag, "_extinct"}, 64'(extinct), 64'(exp_ext));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One generation; wrap_en is flipped after launch to confirm it was latched.
    task automatic do_step(input bit wr, input string tag);
        int cyc, dones;
        wrap_en = wr; step = 1'b1;
        tick();
        step = 1'b0; wrap_en = ~wr;
        cyc = 0; dones = 0;
        while (busy && cyc < 4 * H) begin
            cyc++;
            if (done) dones++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'(H));
        if (done) dones++;
        tick();
        if (done) dones++;
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
        model_step(wr);
    endtask

    initial begin
        int gens, cyc, t1, t2;

        // Reset values
        repeat (2) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_gen", 64'(gen_count), 64'd0);
        chk("rst_extinct", 64'(extinct), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < H; r++) m[r] = '0;
        check_grid("rst_grid");

        // Blinker, dead border
        write_row(4, 32'h20); write_row(5, 32'h20); write_row(6, 32'h20);
        do_step(1'b0, "blinker");
        check_grid("blinker");
        rd_row = 4'd5; tick();
        chk("blinker_row5", 64'(rd_data), 64'h70);
        check_status("blinker");

        // Glider on torus for 128 generations with run held high
        do_clear();
        write_row(1, 32'h4); write_row(2, 32'h8); write_row(3, 32'hE);
        saved = m;
        run = 1'b1; wrap_en = 1'b1;
        gens = 0; cyc = 0; t1 = 0; t2 = 0;
        while (gens < 128 && cyc < 128 * (H + 1) + 50) begin
            tick();
            cyc++;
            if (done) begin
                gens++;
                if (gens == 1) t1 = cyc;
                if (gens == 2) t2 = cyc;
                if (gens == 128) run = 1'b0;
            end
        end
        chk("glider_gens_seen", 64'(gens), 64'd128);
        chk("glider_period", 64'(t2 - t1), 64'(H + 1));
        tick();
        for (int g = 0; g < 128; g++) model_step(1'b1);
        check_grid("glider_model");
        m = saved;
        check_grid("glider_initial");
        check_status("glider");

        // Border mode: block in the top-right corner plus a blinker in column 0
        do_clear();
        write_row(0, 32'hC000_0000); write_row(1, 32'hC000_0001);
        write_row(2, 32'h1); write_row(3, 32'h1);
        saved = m;
        do_step(1'b0, "border_dead");
        check_grid("border_dead");
        rd_row = 4'd0; tick();
        chk("border_dead_block0", 64'(rd_data & 32'hC000_0000), 64'hC000_0000);
        rd_row = 4'd1; tick();
        chk("border_dead_block1", 64'(rd_data & 32'hC000_0000), 64'hC000_0000);
        do_clear();
        for (int r = 0; r < 4; r++) write_row(r, saved[r]);
        do_step(1'b1, "border_wrap");
        check_grid("border_wrap");
        check_status("border_wrap");

        // Single live cell dies out
        do_clear();
        write_row(7, 32'h200);
        do_step(1'b0, "single");
        check_grid("single");
        check_status("single");
        chk("single_extinct_set", 64'(extinct), 64'd1);

        // Inputs during busy are dropped; clear beats wr_en in IDLE
        do_clear();
        write_row(8, 32'h0003_8000);
        wrap_en = 1'b0; step = 1'b1;
        tick();
        wr_en = 1'b1; wr_row = 4'd2; wr_data = '1; clear = 1'b1;
        cyc = 0;
        while (busy && cyc < 4 * H) begin
            cyc++;
            tick();
        end
        wr_en = 1'b0; clear = 1'b0; step = 1'b0;
        chk("ignore_busy_cycles", 64'(cyc), 64'(H));
        model_step(1'b0);
        tick();
        check_grid("ignore");
        check_status("ignore");
        clear = 1'b1; wr_en = 1'b1; wr_row = 4'd3; wr_data = 32'h1234_5678;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        for (int r = 0; r < H; r++) m[r] = '0;
        exp_gen = '0; exp_ext = 1'b0;
        check_grid("prio");
        check_status("prio");

        // Randomized generations against the model
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < H; r++) write_row(r, W'($urandom() & $urandom()));
            do_step(1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
            check_grid($sformatf("rand%0d", it));
            check_status($sformatf("rand%0d", it));
        end

        // Reset during row 3 of a generation
        write_row(10, 32'h700);
        wrap_en = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        repeat (3) tick();
        rd_row = 4'd10;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_gen", 64'(gen_count), 64'd0);
        chk("midrst_rd_data", 64'(rd_data), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int r = 0; r < H; r++) m[r] = '0;
        exp_gen = '0; exp_ext = 1'b0;
        check_grid("midrst_grid");
        write_row(5, 32'h1C0);
        do_step(1'b0, "post_rst");
        check_grid("post_rst");
        check_status("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
